// File: rtl/usr_cmd_sequencer_if.sv
// Command/replay bundle between an upstream command source and the
// shift-register sequencer. The master issues commands and observes the
// replayed register controls. The slave is the sequencer itself.
interface usr_cmd_sequencer_if #(
   parameter int CNT_W = 3,
   parameter int DEPTH = 4
);
   localparam int LW = $clog2(DEPTH) + 1;

   logic             abort;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [CNT_W-1:0] cmd_cnt;
   logic [3:0]       cmd_data;
   logic [1:0]       sr_mode;
   logic [3:0]       sr_in;
   logic             busy;
   logic             cmd_done;
   logic [LW-1:0]    level;

   modport master (
      output abort, cmd_valid, cmd_op, cmd_cnt, cmd_data,
      input  cmd_ready, sr_mode, sr_in, busy, cmd_done, level
   );

   modport slave (
      input  abort, cmd_valid, cmd_op, cmd_cnt, cmd_data,
      output cmd_ready, sr_mode, sr_in, busy, cmd_done, level
   );
endinterface

// File: rtl/usr_cmd_sequencer.sv
// Command sequencer for a 4-bit universal shift register.
// Buffers {op, count, data} commands in a small FIFO and replays each one
// onto the register's mode/in controls for count+1 consecutive cycles.
// Back-to-back commands are replayed with no idle cycle between them.
// All replay outputs are registered and are computed from next-state values,
// so they always describe the state/step the block is currently in.
module usr_cmd_sequencer #(
   parameter int CNT_W = 3,
   parameter int DEPTH = 4
) (
   input logic                clk,
   input logic                rst,
   usr_cmd_sequencer_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;
   localparam int EW = 2 + CNT_W + 4;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Replay value {mode, in} for one step of a command; shift steps walk
   // the data word LSB first and wrap every four steps.
   function automatic logic [5:0] step_out(input logic [1:0]       op,
                                           input logic [3:0]       data,
                                           input logic [CNT_W-1:0] k);
      logic [CNT_W+1:0] kx;
      logic [1:0]       idx;
      logic [5:0]       res;
      kx  = {2'b00, k};
      idx = kx[1:0];
      case (op)
         2'b11:         res = {2'b11, data};
         2'b01, 2'b10:  res = {op, 3'b000, data[idx]};
         2'b00:         res = 6'b00_0000;
         default:       res = 6'b00_0000;
      endcase
      return res;
   endfunction

   // FIFO storage and bookkeeping
   logic [EW-1:0]    mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q;
   logic [PW-1:0]    rd_ptr_q;
   logic [LW-1:0]    level_q;
   logic [LW-1:0]    level_d;

   // Sequencer state and the command currently being replayed
   state_t           state_q;
   state_t           state_d;
   logic [CNT_W-1:0] k_q;
   logic [CNT_W-1:0] k_d;
   logic [1:0]       cur_op_q;
   logic [1:0]       cur_op_d;
   logic [CNT_W-1:0] cur_cnt_q;
   logic [CNT_W-1:0] cur_cnt_d;
   logic [3:0]       cur_data_q;
   logic [3:0]       cur_data_d;

   // Registered outputs
   logic [1:0]       sr_mode_q;
   logic [1:0]       sr_mode_d;
   logic [3:0]       sr_in_q;
   logic [3:0]       sr_in_d;
   logic             busy_q;
   logic             busy_d;
   logic             done_q;
   logic             done_d;

   logic             full_s;
   logic             empty_s;
   logic             ready_s;
   logic             push_s;
   logic             pop_s;
   logic [EW-1:0]    head_s;
   logic [EW-1:0]    entry_s;

   assign full_s  = (level_q == LW'(DEPTH));
   assign empty_s = (level_q == {LW{1'b0}});
   // Ready deliberately ignores a same-cycle pop: a full FIFO always stalls.
   assign ready_s = rst & ~full_s & ~bus.abort;
   assign push_s  = bus.cmd_valid & ready_s;
   assign head_s  = mem_q[rd_ptr_q];
   assign entry_s = {bus.cmd_op, bus.cmd_cnt, bus.cmd_data};

   assign bus.cmd_ready = ready_s;
   assign bus.sr_mode   = sr_mode_q;
   assign bus.sr_in     = sr_in_q;
   assign bus.busy      = busy_q;
   assign bus.cmd_done  = done_q;
   assign bus.level     = level_q;

   // Next-state: step counting, command pops and abort flush
   always_comb begin
      state_d    = state_q;
      k_d        = k_q;
      cur_op_d   = cur_op_q;
      cur_cnt_d  = cur_cnt_q;
      cur_data_d = cur_data_q;
      pop_s      = 1'b0;
      if (bus.abort) begin
         state_d = ST_IDLE;
         k_d     = {CNT_W{1'b0}};
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (!empty_s) begin
                  pop_s                              = 1'b1;
                  {cur_op_d, cur_cnt_d, cur_data_d}  = head_s;
                  k_d                                = {CNT_W{1'b0}};
                  state_d                            = ST_RUN;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_RUN: begin
               if (k_q != cur_cnt_q) begin
                  k_d = k_q + CNT_W'(1);
               end else if (!empty_s) begin
                  pop_s                              = 1'b1;
                  {cur_op_d, cur_cnt_d, cur_data_d}  = head_s;
                  k_d                                = {CNT_W{1'b0}};
               end else begin
                  state_d = ST_IDLE;
                  k_d     = {CNT_W{1'b0}};
               end
            end
            default: begin
               state_d = ST_IDLE;
               k_d     = {CNT_W{1'b0}};
            end
         endcase
      end
   end

   // Occupancy update: abort empties, otherwise +push -pop
   always_comb begin
      level_d = level_q;
      if (bus.abort) begin
         level_d = {LW{1'b0}};
      end else begin
         level_d = level_q + LW'(push_s) - LW'(pop_s);
      end
   end

   // Output decode from the state/step the block is about to be in
   always_comb begin
      sr_mode_d = 2'b00;
      sr_in_d   = 4'b0000;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      if (state_d == ST_RUN) begin
         {sr_mode_d, sr_in_d} = step_out(cur_op_d, cur_data_d, k_d);
         busy_d               = 1'b1;
         done_d               = (k_d == cur_cnt_d);
      end else begin
         busy_d = 1'b0;
      end
   end

   // FIFO storage and pointers; abort resets both pointers to a clean empty
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= {EW{1'b0}};
         end
         wr_ptr_q <= {PW{1'b0}};
         rd_ptr_q <= {PW{1'b0}};
      end else if (bus.abort) begin
         wr_ptr_q <= {PW{1'b0}};
         rd_ptr_q <= {PW{1'b0}};
      end else begin
         if (push_s) begin
            mem_q[wr_ptr_q] <= entry_s;
            wr_ptr_q        <= wr_ptr_q + PW'(1);
         end
         if (pop_s) begin
            rd_ptr_q <= rd_ptr_q + PW'(1);
         end
      end
   end

   // Sequencer, occupancy and output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         k_q        <= {CNT_W{1'b0}};
         cur_op_q   <= 2'b00;
         cur_cnt_q  <= {CNT_W{1'b0}};
         cur_data_q <= 4'b0000;
         level_q    <= {LW{1'b0}};
         sr_mode_q  <= 2'b00;
         sr_in_q    <= 4'b0000;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         k_q        <= k_d;
         cur_op_q   <= cur_op_d;
         cur_cnt_q  <= cur_cnt_d;
         cur_data_q <= cur_data_d;
         level_q    <= level_d;
         sr_mode_q  <= sr_mode_d;
         sr_in_q    <= sr_in_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end
endmodule

// File: tb/tb_usr_cmd_sequencer.sv
// Bench for usr_cmd_sequencer: directed scenarios followed by random
// traffic, all compared against a reference model that expands each
// accepted command into its list of replay steps.
module tb_usr_cmd_sequencer;
   localparam int CNT_W = 3;
   localparam int DEPTH = 4;

   typedef struct {
      logic [1:0] op;
      logic [2:0] cnt;
      logic [3:0] data;
   } cmd_t;

   typedef struct {
      logic [1:0] mode;
      logic [3:0] sin;
      logic       last;
   } step_t;

   logic   clk;
   logic   rst;
   int     n_tests;
   int     n_fail;
   cmd_t   pend[$];
   step_t  steps[$];

   usr_cmd_sequencer_if #(.CNT_W(CNT_W), .DEPTH(DEPTH)) bus ();

   usr_cmd_sequencer #(.CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Expand one command into its replay steps
   task automatic expand(input cmd_t c);
      for (int j = 0; j <= int'(c.cnt); j++) begin
         step_t s;
         case (c.op)
            2'b11: begin s.mode = 2'b11; s.sin = c.data; end
            2'b01, 2'b10: begin s.mode = c.op; s.sin = {3'b000, c.data[j % 4]}; end
            default: begin s.mode = 2'b00; s.sin = 4'b0000; end
         endcase
         s.last = (j == int'(c.cnt));
         steps.push_back(s);
      end
   endtask

   task automatic check_outputs();
      if (steps.size() > 0) begin
         check_eq("sr_mode", 32'(bus.sr_mode), 32'(steps[0].mode));
         check_eq("sr_in", 32'(bus.sr_in), 32'(steps[0].sin));
         check_eq("busy", 32'(bus.busy), 32'd1);
         check_eq("cmd_done", 32'(bus.cmd_done), 32'(steps[0].last));
      end else begin
         check_eq("sr_mode_idle", 32'(bus.sr_mode), 32'd0);
         check_eq("sr_in_idle", 32'(bus.sr_in), 32'd0);
         check_eq("busy_idle", 32'(bus.busy), 32'd0);
         check_eq("cmd_done_idle", 32'(bus.cmd_done), 32'd0);
      end
      check_eq("level", 32'(bus.level), 32'(pend.size()));
   endtask

   // One clock cycle: check state, drive inputs, check ready, advance model
   task automatic cycle(input logic v, input logic [1:0] op, input logic [2:0] cnt,
                        input logic [3:0] d, input logic ab);
      logic exp_ready;
      cmd_t c;
      @(negedge clk);
      check_outputs();
      bus.cmd_valid = v;
      bus.cmd_op    = op;
      bus.cmd_cnt   = cnt;
      bus.cmd_data  = d;
      bus.abort     = ab;
      #1;
      exp_ready = (pend.size() < DEPTH) && !ab;
      check_eq("cmd_ready", 32'(bus.cmd_ready), 32'(exp_ready));
      @(posedge clk);
      if (ab) begin
         pend.delete();
         steps.delete();
      end else begin
         if (steps.size() > 0) void'(steps.pop_front());
         if (steps.size() == 0 && pend.size() > 0) expand(pend.pop_front());
         if (v && exp_ready) begin
            c.op = op; c.cnt = cnt; c.data = d;
            pend.push_back(c);
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 2'b00, 3'd0, 4'h0, 1'b0);
   endtask

   initial begin
      n_tests       = 0;
      n_fail        = 0;
      rst           = 1'b0;
      bus.abort     = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 2'b00;
      bus.cmd_cnt   = 3'd0;
      bus.cmd_data  = 4'h0;

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_sr_mode", 32'(bus.sr_mode), 32'd0);
      check_eq("rst_sr_in", 32'(bus.sr_in), 32'd0);
      check_eq("rst_busy", 32'(bus.busy), 32'd0);
      check_eq("rst_done", 32'(bus.cmd_done), 32'd0);
      check_eq("rst_level", 32'(bus.level), 32'd0);
      check_eq("rst_ready", 32'(bus.cmd_ready), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_eq("ready_after_rst", 32'(bus.cmd_ready), 32'd1);

      // Single load
      cycle(1'b1, 2'b11, 3'd0, 4'b1010, 1'b0);
      idle(4);

      // Serial wrap
      cycle(1'b1, 2'b10, 3'd5, 4'b0110, 1'b0);
      idle(9);

      // Back-to-back load, shift-right, hold
      cycle(1'b1, 2'b11, 3'd0, 4'b1111, 1'b0);
      cycle(1'b1, 2'b01, 3'd1, 4'b0001, 1'b0);
      cycle(1'b1, 2'b00, 3'd2, 4'b0000, 1'b0);
      idle(8);

      // Full FIFO with cmd_valid held high
      for (int i = 0; i < 24; i++) cycle(1'b1, 2'b01, 3'd7, 4'($urandom_range(0, 15)), 1'b0);
      idle(60);

      // Abort during step 2 of a count-7 shift with two queued commands
      cycle(1'b1, 2'b01, 3'd7, 4'b1011, 1'b0);
      cycle(1'b1, 2'b11, 3'd3, 4'b0101, 1'b0);
      cycle(1'b1, 2'b10, 3'd2, 4'b1100, 1'b0);
      cycle(1'b1, 2'b11, 3'd1, 4'b1001, 1'b1);
      idle(4);

      // Asynchronous reset in the middle of a count-7 shift-left
      cycle(1'b1, 2'b10, 3'd7, 4'b1101, 1'b0);
      idle(3);
      @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      check_eq("arst_sr_mode", 32'(bus.sr_mode), 32'd0);
      check_eq("arst_sr_in", 32'(bus.sr_in), 32'd0);
      check_eq("arst_busy", 32'(bus.busy), 32'd0);
      check_eq("arst_level", 32'(bus.level), 32'd0);
      check_eq("arst_ready", 32'(bus.cmd_ready), 32'd0);
      pend.delete();
      steps.delete();
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_eq("arst_ready_release", 32'(bus.cmd_ready), 32'd1);

      // Random traffic
      for (int i = 0; i < 1500; i++) begin
         cycle($urandom_range(0, 99) < 60,
               2'($urandom_range(0, 3)),
               3'($urandom_range(0, 7)),
               4'($urandom_range(0, 15)),
               $urandom_range(0, 99) < 3);
      end
      idle(50);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
